// File: rtl/bilinear_pkg.sv
// Purpose: shared widths, rounding constant and weight calculation for the bilinear scaler pipe.
// Latency: n/a (package only).
// Backpressure: n/a.
package bilinear_pkg;

    // Widest fraction the shared weight struct can carry; instances use FRAC_W <= MAX_FRAC_W.
    localparam int MAX_FRAC_W = 12;
    localparam int MAX_WGT_W  = 2 * MAX_FRAC_W + 2;

    // Width of one 2-D weight wx_i*wy_j; its maximum is 2^(2*FRAC_W).
    function automatic int wgt_w(input int frac_w);
        return 2 * frac_w + 2;
    endfunction

    // Width of the weighted sum of four neighbours.
    function automatic int sum_w(input int pix_w, input int frac_w);
        return pix_w + 2 * frac_w + 2;
    endfunction

    // Half an output LSB, added before the final right shift.
    function automatic int round_c(input int frac_w);
        return 1 << (2 * frac_w - 1);
    endfunction

    typedef struct packed {
        logic [MAX_WGT_W-1:0] w00;
        logic [MAX_WGT_W-1:0] w10;
        logic [MAX_WGT_W-1:0] w01;
        logic [MAX_WGT_W-1:0] w11;
    } weights_t;

    // Four 2-D weights from the Q0.frac_w fractions; they always sum to 2^(2*frac_w).
    function automatic weights_t calc_weights(input logic [MAX_FRAC_W-1:0] fx,
                                              input logic [MAX_FRAC_W-1:0] fy,
                                              input int                    frac_w);
        logic [MAX_FRAC_W:0] one;
        logic [MAX_FRAC_W:0] wx0;
        logic [MAX_FRAC_W:0] wx1;
        logic [MAX_FRAC_W:0] wy0;
        logic [MAX_FRAC_W:0] wy1;
        weights_t            w;
        one   = (MAX_FRAC_W + 1)'(1) << frac_w;
        wx1   = {1'b0, fx};
        wy1   = {1'b0, fy};
        wx0   = one - wx1;
        wy0   = one - wy1;
        w.w00 = MAX_WGT_W'(wx0) * MAX_WGT_W'(wy0);
        w.w10 = MAX_WGT_W'(wx1) * MAX_WGT_W'(wy0);
        w.w01 = MAX_WGT_W'(wx0) * MAX_WGT_W'(wy1);
        w.w11 = MAX_WGT_W'(wx1) * MAX_WGT_W'(wy1);
        return w;
    endfunction

endpackage

// File: rtl/bilinear_lane.sv
// Purpose: one colour channel of the interpolator: S2 weighted products, S3 sum/round/saturate.
// Latency: 2 clk (S2 product register, S3 result register).
// Backpressure: each register only loads on its enable; stalled stages hold their contents.
// Ports: clk/rst_n; en2_i/en3_i load enables for S2/S3; p00_i..p11_i neighbour samples (S1);
//        w_i weights derived from S1 fractions; pix_o registered result.
module bilinear_lane
    import bilinear_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en2_i,
    input  logic             en3_i,
    input  logic [PIX_W-1:0] p00_i,
    input  logic [PIX_W-1:0] p10_i,
    input  logic [PIX_W-1:0] p01_i,
    input  logic [PIX_W-1:0] p11_i,
    input  weights_t         w_i,
    output logic [PIX_W-1:0] pix_o
);

    localparam int WW    = wgt_w(FRAC_W);
    localparam int SW    = sum_w(PIX_W, FRAC_W);
    localparam int SHIFT = 2 * FRAC_W;
    localparam logic [SW-1:0] ROUND   = SW'(round_c(FRAC_W));
    localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

    logic [3:0][SW-1:0] prod_d;
    logic [3:0][SW-1:0] prod_q;
    logic [SW-1:0]      sum;
    logic [SW-1:0]      rounded;
    logic [SW-1:0]      shifted;
    logic [PIX_W-1:0]   pix_d;
    logic [PIX_W-1:0]   pix_q;

    always_comb begin
        prod_d[0] = SW'(WW'(w_i.w00)) * SW'(p00_i);
        prod_d[1] = SW'(WW'(w_i.w10)) * SW'(p10_i);
        prod_d[2] = SW'(WW'(w_i.w01)) * SW'(p01_i);
        prod_d[3] = SW'(WW'(w_i.w11)) * SW'(p11_i);
        sum       = prod_q[0] + prod_q[1] + prod_q[2] + prod_q[3];
        rounded   = sum + ROUND;
        shifted   = rounded >> SHIFT;
        // Weights sum to exactly one, so this clamp only guards against arithmetic surprises.
        pix_d     = (shifted > PIX_MAX) ? '1 : shifted[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            pix_q  <= '0;
        end else begin
            if (en2_i) prod_q <= prod_d;
            if (en3_i) pix_q  <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/bilinear_pipe_nch.sv
// Purpose: fully pipelined NCH-channel bilinear interpolator, one output pixel per clock.
// Latency: 3 clk from accepted input to out_valid (S1 regs, S2 products, S3 result).
// Backpressure: bubble-collapsing valid/ready per stage; a full pipe stalls only when out_ready=0.
// Ports: in_valid/in_ready + in_p00/p10/p01/p11 (channel c at [c*PIX_W +: PIX_W]), in_fx/in_fy
//        (Q0.FRAC_W), in_tag; out_valid/out_ready + out_pix/out_tag; busy = any stage occupied.
module bilinear_pipe_nch
    import bilinear_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int NCH    = 1,
    parameter int TAG_W  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*PIX_W-1:0] in_p00,
    input  logic [NCH*PIX_W-1:0] in_p10,
    input  logic [NCH*PIX_W-1:0] in_p01,
    input  logic [NCH*PIX_W-1:0] in_p11,
    input  logic [FRAC_W-1:0]    in_fx,
    input  logic [FRAC_W-1:0]    in_fy,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*PIX_W-1:0] out_pix,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int PW = NCH * PIX_W;

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic rdy1, rdy2, rdy3;
    logic ld1, ld2, ld3;

    logic [PW-1:0]     p00_q, p10_q, p01_q, p11_q;
    logic [FRAC_W-1:0] fx_q, fy_q;
    logic [TAG_W-1:0]  tag1_q, tag2_q, tag3_q;
    weights_t          w_s1;

    always_comb begin
        // A stage can take a new beat if it is empty or its occupant leaves this cycle.
        rdy3 = !v3_q | out_ready;
        rdy2 = !v2_q | rdy3;
        rdy1 = !v1_q | rdy2;
        // Data registers load only for real beats, so a drained stage keeps its last value.
        ld1  = rdy1 & in_valid;
        ld2  = rdy2 & v1_q;
        ld3  = rdy3 & v2_q;
        v1_d = rdy1 ? in_valid : v1_q;
        v2_d = rdy2 ? v1_q     : v2_q;
        v3_d = rdy3 ? v2_q     : v3_q;
        w_s1 = calc_weights(MAX_FRAC_W'(fx_q), MAX_FRAC_W'(fy_q), FRAC_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p00_q  <= '0;
            p10_q  <= '0;
            p01_q  <= '0;
            p11_q  <= '0;
            fx_q   <= '0;
            fy_q   <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (ld1) begin
                p00_q  <= in_p00;
                p10_q  <= in_p10;
                p01_q  <= in_p01;
                p11_q  <= in_p11;
                fx_q   <= in_fx;
                fy_q   <= in_fy;
                tag1_q <= in_tag;
            end
            if (ld2) tag2_q <= tag1_q;
            if (ld3) tag3_q <= tag2_q;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        bilinear_lane #(
            .PIX_W  (PIX_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en2_i (ld2),
            .en3_i (ld3),
            .p00_i (p00_q[c*PIX_W +: PIX_W]),
            .p10_i (p10_q[c*PIX_W +: PIX_W]),
            .p01_i (p01_q[c*PIX_W +: PIX_W]),
            .p11_i (p11_q[c*PIX_W +: PIX_W]),
            .w_i   (w_s1),
            .pix_o (out_pix[c*PIX_W +: PIX_W])
        );
    end

    assign in_ready  = rdy1;
    assign out_valid = v3_q;
    assign out_tag   = tag3_q;
    assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_bilinear_pipe_nch.sv
module tb_bilinear_pipe_nch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Gray instance: PIX_W=8, FRAC_W=8, NCH=1, TAG_W=4
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_p00, in_p10, in_p01, in_p11, in_fx, in_fy, out_pix;
    logic [3:0] in_tag, out_tag;

    // RGB instance: PIX_W=10, FRAC_W=6, NCH=3, TAG_W=1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [29:0] b_p00, b_p10, b_p01, b_p11, b_out_pix;
    logic [5:0]  b_fx, b_fy;
    logic        b_tag, b_out_tag;

    bilinear_pipe_nch #(.PIX_W(8), .FRAC_W(8), .NCH(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p00(in_p00), .in_p10(in_p10), .in_p01(in_p01), .in_p11(in_p11),
        .in_fx(in_fx), .in_fy(in_fy), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_tag(out_tag), .busy(busy)
    );

    bilinear_pipe_nch #(.PIX_W(10), .FRAC_W(6), .NCH(3), .TAG_W(1)) dut_rgb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_p00(b_p00), .in_p10(b_p10), .in_p01(b_p01), .in_p11(b_p11),
        .in_fx(b_fx), .in_fy(b_fy), .in_tag(b_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pix(b_out_pix), .out_tag(b_out_tag), .busy(b_busy)
    );

    typedef struct {
        logic [7:0] p00, p10, p01, p11, fx, fy;
        logic [3:0] tag;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] pix;
        logic [3:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   first_out_cyc = 0;
    int   last_out_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference bilinear interpolation straight from the weight/round/saturate definition.
    function automatic longint gold(input longint p00, input longint p10, input longint p01,
                                    input longint p11, input longint fx, input longint fy,
                                    input int pw, input int fw);
        longint one, wx0, wx1, wy0, wy1, s, r, mx;
        one = longint'(1) << fw;
        wx0 = one - fx;  wx1 = fx;
        wy0 = one - fy;  wy1 = fy;
        s   = wx0*wy0*p00 + wx1*wy0*p10 + wx0*wy1*p01 + wx1*wy1*p11;
        r   = (s + (longint'(1) << (2*fw - 1))) >> (2*fw);
        mx  = (longint'(1) << pw) - 1;
        return (r > mx) ? mx : r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every beat that leaves the gray instance is checked against the queue head.
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            chk("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                chk("out_pix", out_pix, sb[0].pix);
                chk("out_tag", out_tag, sb[0].tag);
                void'(sb.pop_front());
            end
            if (n_out == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_out++;
        end
    end

    task automatic set_in(input vec_t v);
        in_p00 = v.p00; in_p10 = v.p10; in_p01 = v.p01; in_p11 = v.p11;
        in_fx  = v.fx;  in_fy  = v.fy;  in_tag = v.tag;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.pix = v.exp;
        e.tag = v.tag;
        sb.push_back(e);
    endtask

    // Present one beat and hold it until the edge that accepts it; leaves in_valid high.
    task automatic drive(input vec_t v);
        logic rd;
        logic done;
        set_in(v);
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rd = in_ready;
            @(posedge clk);
            #1;
            if (rd) begin
                push_exp(v);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", in_ready, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic run_b(input logic [29:0] a, input logic [29:0] b, input logic [29:0] c,
                         input logic [29:0] d, input logic [5:0] fx, input logic [5:0] fy,
                         output logic [29:0] res);
        logic got;
        b_p00 = a; b_p10 = b; b_p01 = c; b_p11 = d;
        b_fx = fx; b_fy = fy; b_tag = 1'b1;
        b_in_valid = 1'b1;
        got = 1'b0;
        res = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = b_in_ready;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        chk("b_accept", got, 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_out_valid) begin
                got = 1'b1;
                res = b_out_pix;
                chk("b_out_tag", b_out_tag, 1);
                chk("b_busy", b_busy, 1);
            end
        end
        chk("b_out_valid", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        vec_t        st[5];
        logic        rd;
        int          k;
        int          cnt;
        logic [29:0] bres;
        longint      e0, e1;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        in_p00 = '0; in_p10 = '0; in_p01 = '0; in_p11 = '0;
        in_fx = '0; in_fy = '0; in_tag = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_p00 = '0; b_p10 = '0; b_p01 = '0; b_p11 = '0;
        b_fx = '0; b_fy = '0; b_tag = 1'b0;

        //                p00     p10     p01     p11     fx      fy      tag   expected
        tbl.push_back('{8'd37,  8'd200, 8'd200, 8'd200, 8'd0,   8'd0,   4'd1, 8'd37 });
        tbl.push_back('{8'd100, 8'd200, 8'd0,   8'd0,   8'd64,  8'd0,   4'd2, 8'd125});
        tbl.push_back('{8'd0,   8'd255, 8'd0,   8'd255, 8'd128, 8'd128, 4'd3, 8'd128});
        tbl.push_back('{8'd90,  8'd90,  8'd90,  8'd90,  8'd200, 8'd17,  4'd4, 8'd90 });
        tbl.push_back('{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 4'd5, 8'd255});
        tbl.push_back('{8'd12,  8'd250, 8'd7,   8'd99,  8'd0,   8'd0,   4'd6, 8'd12 });
        tbl.push_back('{8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255, 4'd7, 8'd253});
        tbl.push_back('{8'd255, 8'd0,   8'd0,   8'd0,   8'd1,   8'd1,   4'd8, 8'd253});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // fx=fy=0 returns p00, with the first output 3 clk after acceptance
        drive(tbl[0]);
        in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(negedge clk);
            if (out_valid) k = i;
        end
        chk("latency", k, 3);
        wait_drain();

        // Remaining directed vectors back to back
        for (int i = 1; i < tbl.size(); i++) drive(tbl[i]);
        in_valid = 1'b0;
        wait_drain();

        // 16 random beats streamed with out_ready held high: one result per clock
        n_out = 0;
        for (int i = 0; i < 16; i++) begin
            v.p00 = 8'($urandom_range(0, 255)); v.p10 = 8'($urandom_range(0, 255));
            v.p01 = 8'($urandom_range(0, 255)); v.p11 = 8'($urandom_range(0, 255));
            v.fx  = 8'($urandom_range(0, 255)); v.fy  = 8'($urandom_range(0, 255));
            v.tag = 4'(i);
            v.exp = 8'(gold(v.p00, v.p10, v.p01, v.p11, v.fx, v.fy, 8, 8));
            drive(v);
        end
        in_valid = 1'b0;
        wait_drain();
        chk("stream_count", n_out, 16);
        chk("stream_span", last_out_cyc - first_out_cyc, 15);

        // Output stall: only 3 beats fit, result held stable, then ordered release
        for (int i = 0; i < 5; i++) begin
            st[i].p00 = 8'($urandom_range(0, 255)); st[i].p10 = 8'($urandom_range(0, 255));
            st[i].p01 = 8'($urandom_range(0, 255)); st[i].p11 = 8'($urandom_range(0, 255));
            st[i].fx  = 8'($urandom_range(0, 255)); st[i].fy  = 8'($urandom_range(0, 255));
            st[i].tag = 4'(9 + i);
            st[i].exp = 8'(gold(st[i].p00, st[i].p10, st[i].p01, st[i].p11,
                                st[i].fx, st[i].fy, 8, 8));
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(st[k]);
            @(negedge clk);
            rd = in_ready;
            @(posedge clk);
            #1;
            if (rd) begin
                push_exp(st[k]);
                k++;
            end
        end
        chk("stall_accepts", k, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_hold_pix", out_pix, st[0].exp);
            chk("stall_hold_tag", out_tag, st[0].tag);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_in(st[3]);
        @(negedge clk);
        chk("full_in_ready", in_ready, 1);
        chk("full_out_valid", out_valid, 1);
        rd = in_ready;
        @(posedge clk);
        #1;
        if (rd) push_exp(st[3]);
        else drive(st[3]);
        drive(st[4]);
        in_valid = 1'b0;
        wait_drain();

        // RGB instance: independent channels
        run_b({10'd0, 10'd10, 10'd1023}, {10'd0, 10'd10, 10'd0},
              {10'd0, 10'd10, 10'd0},    {10'd0, 10'd10, 10'd1023}, 6'd32, 6'd32, bres);
        chk("rgb_ch0_mid", bres[9:0], 512);
        chk("rgb_ch1_flat", bres[19:10], 10);
        chk("rgb_ch2_zero", bres[29:20], 0);
        e0 = gold(1023, 0, 0, 1023, 10, 50, 10, 6);
        e1 = gold(5, 900, 300, 77, 10, 50, 10, 6);
        run_b({10'd1023, 10'd5, 10'd1023}, {10'd1023, 10'd900, 10'd0},
              {10'd1023, 10'd300, 10'd0},  {10'd1023, 10'd77, 10'd1023}, 6'd10, 6'd50, bres);
        chk("rgb2_ch0", bres[9:0], e0);
        chk("rgb2_ch1", bres[19:10], e1);
        chk("rgb2_ch2_max", bres[29:20], 1023);

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive(st[0]);
        drive(st[1]);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_pix", out_pix, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("post_rst_no_output", cnt, 0);
        chk("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
